// File: rtl/posit_divsqrt_issue.sv
// Request sequencer in front of the posit div/sqrt wrapper.
// Queues tagged requests, issues one at a time with a single-cycle start
// pulse, waits for Done and hands the tagged result back downstream.
//
// Handshakes: on both the request and the result channel a beat transfers
// on a rising edge where valid and ready are both high. Valid is never
// withdrawn before it transfers, except by flush or reset. Ready may depend
// on internal state only, never combinationally on the same channel's valid.
module posit_divsqrt_issue #(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int RM_W  = 3
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Flush_SI,
  input  logic             In_valid_SI,
  output logic             In_ready_SO,
  input  logic             In_op_SI,
  input  logic [N-1:0]     In_a_DI,
  input  logic [N-1:0]     In_b_DI,
  input  logic [RM_W-1:0]  In_rm_DI,
  input  logic [TAG_W-1:0] In_tag_DI,
  output logic             Div_start_SO,
  output logic             Sqrt_start_SO,
  output logic [N-1:0]     Operand_a_DO,
  output logic [N-1:0]     Operand_b_DO,
  output logic [RM_W-1:0]  RM_SO,
  output logic             Kill_SO,
  input  logic             Ready_SI,
  input  logic             Done_SI,
  input  logic [N-1:0]     Result_DI,
  input  logic [4:0]       Fflags_DI,
  output logic             Out_valid_SO,
  input  logic             Out_ready_SI,
  output logic [N-1:0]     Out_result_DO,
  output logic [4:0]       Out_fflags_DO,
  output logic [TAG_W-1:0] Out_tag_DO,
  output logic [1:0]       Dbg_state_SO
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic             op;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [RM_W-1:0]  rm;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_e           state;
  req_t             mem [DEPTH];
  req_t             in_req;
  req_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] issue_tag;

  assign in_req      = '{op: In_op_SI, a: In_a_DI, b: In_b_DI, rm: In_rm_DI, tag: In_tag_DI};
  assign head        = mem[rd_ptr];
  assign fifo_empty  = (count == '0);
  // Ready comes from the registered count only, so a pop never reaches it combinationally.
  assign In_ready_SO = (count != CW'(DEPTH));
  assign push        = In_valid_SI & In_ready_SO & ~Flush_SI;
  assign pop         = (state == IDLE) & ~fifo_empty & Ready_SI & ~Flush_SI;
  assign Dbg_state_SO = state;

  // Request storage: written on accept, no reset needed since count guards reads.
  always_ff @(posedge Clk_CI) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  // FIFO pointers and occupancy; flush empties the queue and ignores a same-cycle push.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || Flush_SI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered start/kill pulses, held operands and captured result.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state         <= IDLE;
      Div_start_SO  <= 1'b0;
      Sqrt_start_SO <= 1'b0;
      Kill_SO       <= 1'b0;
      Out_valid_SO  <= 1'b0;
      Operand_a_DO  <= '0;
      Operand_b_DO  <= '0;
      RM_SO         <= '0;
      issue_tag     <= '0;
      Out_result_DO <= '0;
      Out_fflags_DO <= '0;
      Out_tag_DO    <= '0;
    end else begin
      Div_start_SO  <= 1'b0;
      Sqrt_start_SO <= 1'b0;
      Kill_SO       <= 1'b0;
      if (Flush_SI) begin
        // Only an operation the wrapper has actually been started on needs killing.
        Kill_SO      <= (state == ISSUE) || (state == WAIT);
        Out_valid_SO <= 1'b0;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (pop) begin
              Operand_a_DO  <= head.a;
              Operand_b_DO  <= head.op ? '0 : head.b;
              RM_SO         <= head.rm;
              issue_tag     <= head.tag;
              Div_start_SO  <= ~head.op;
              Sqrt_start_SO <= head.op;
              state         <= ISSUE;
            end
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (Done_SI) begin
              Out_result_DO <= Result_DI;
              Out_fflags_DO <= Fflags_DI;
              Out_tag_DO    <= issue_tag;
              Out_valid_SO  <= 1'b1;
              state         <= RESP;
            end
          end
          RESP: begin
            if (Out_ready_SI) begin
              Out_valid_SO <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
